// File: rtl/sc_acc_array.sv
// Window accumulator array: popcounts ADIM stochastic product bits per row each cycle
// and sums them over a 2^OWID-cycle window, presenting stable totals to the activation stage.
module sc_acc_array #(
    parameter int IDIM = 16,
    parameter int ADIM = 128,
    parameter int OWID = 8,
    parameter int IWID = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iStart,
    input  logic [ADIM-1:0] iBit  [IDIM],
    output logic [IWID-1:0] oData [IDIM],
    output logic            oValid,
    output logic            oBusy
);

    localparam int PCW = $clog2(ADIM + 1);

    if (IWID < $clog2(ADIM * (2 ** OWID) + 1)) begin : g_iwid_too_small
        $error("sc_acc_array: IWID too narrow for ADIM*2^OWID");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [OWID-1:0] cnt_r;
    logic [PCW-1:0]  pc_r   [IDIM];
    logic [IWID-1:0] acc_r  [IDIM];
    logic            start_s;
    logic            sample_s;
    logic            last_s;
    logic            drain_s;

    function automatic logic [PCW-1:0] popcount(input logic [ADIM-1:0] v);
        logic [PCW-1:0] s;
        s = {PCW{1'b0}};
        for (int i = 0; i < ADIM; i++) begin
            s = s + {{(PCW-1){1'b0}}, v[i]};
        end
        return s;
    endfunction

    function automatic logic [IWID-1:0] pc_ext(input logic [PCW-1:0] p);
        return {{(IWID-PCW){1'b0}}, p};
    endfunction

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; a start request is only honoured from IDLE or DONE
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  if (iStart) state_next_s = ST_RUN;   else state_next_s = ST_IDLE;
            ST_RUN:   if (last_s) state_next_s = ST_DRAIN; else state_next_s = ST_RUN;
            ST_DRAIN: state_next_s = ST_DONE;
            ST_DONE:  if (iStart) state_next_s = ST_RUN;   else state_next_s = ST_DONE;
            default:  state_next_s = ST_IDLE;
        endcase
    end

    // Control strobes decoded from the current state
    always_comb begin
        start_s  = 1'b0;
        sample_s = 1'b0;
        drain_s  = 1'b0;
        last_s   = 1'b0;
        case (state_r)
            ST_IDLE:  start_s = iStart;
            ST_RUN: begin
                sample_s = 1'b1;
                last_s   = (cnt_r == {OWID{1'b1}});
            end
            ST_DRAIN: drain_s = 1'b1;
            ST_DONE:  start_s = iStart;
            default:  start_s = 1'b0;
        endcase
    end

    // Shared window sample counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {OWID{1'b0}};
        end else if (start_s) begin
            cnt_r <= {OWID{1'b0}};
        end else if (sample_s) begin
            cnt_r <= cnt_r + {{(OWID-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Per-row popcount stage and accumulator; pc is cleared at start so the
    // first RUN edge adds zero and the last sample is folded in during DRAIN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < IDIM; r++) begin
                pc_r[r]  <= {PCW{1'b0}};
                acc_r[r] <= {IWID{1'b0}};
                oData[r] <= {IWID{1'b0}};
            end
        end else begin
            for (int r = 0; r < IDIM; r++) begin
                if (start_s) begin
                    pc_r[r]  <= {PCW{1'b0}};
                    acc_r[r] <= {IWID{1'b0}};
                    oData[r] <= oData[r];
                end else if (sample_s) begin
                    pc_r[r]  <= popcount(iBit[r]);
                    acc_r[r] <= acc_r[r] + pc_ext(pc_r[r]);
                    oData[r] <= oData[r];
                end else if (drain_s) begin
                    pc_r[r]  <= pc_r[r];
                    acc_r[r] <= acc_r[r];
                    oData[r] <= acc_r[r] + pc_ext(pc_r[r]);
                end else begin
                    pc_r[r]  <= pc_r[r];
                    acc_r[r] <= acc_r[r];
                    oData[r] <= oData[r];
                end
            end
        end
    end

    // Registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oValid <= 1'b0;
            oBusy  <= 1'b0;
        end else if (start_s) begin
            oValid <= 1'b0;
            oBusy  <= 1'b1;
        end else if (drain_s) begin
            oValid <= 1'b1;
            oBusy  <= 1'b0;
        end else begin
            oValid <= oValid;
            oBusy  <= oBusy;
        end
    end

endmodule

// File: tb/tb_sc_acc_array.sv
// Randomized bench for sc_acc_array: window totals are predicted by summing the
// ones presented during the N cycles that follow each accepted start.
module tb_sc_acc_array;

    localparam int IDIM = 16;
    localparam int ADIM = 128;
    localparam int OWID = 8;
    localparam int IWID = 32;
    localparam int N    = 2 ** OWID;

    logic            clk;
    logic            rst_n;
    logic            iStart;
    logic [ADIM-1:0] iBit  [IDIM];
    logic [IWID-1:0] oData [IDIM];
    logic            oValid;
    logic            oBusy;

    int          total_cnt;
    int          bad_cnt;
    int          exp_sum  [IDIM];
    logic [63:0] held     [IDIM];
    logic        exp_valid;

    sc_acc_array #(.IDIM(IDIM), .ADIM(ADIM), .OWID(OWID), .IWID(IWID)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .iStart (iStart),
        .iBit   (iBit),
        .oData  (oData),
        .oValid (oValid),
        .oBusy  (oBusy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0 zeros, 1 all ones, 2 low half ones, 3 exactly r ones (rotated), other random
    function automatic logic [ADIM-1:0] gen(input int mode, input int r);
        logic [ADIM-1:0] v;
        int s;
        v = {ADIM{1'b0}};
        case (mode)
            0: v = {ADIM{1'b0}};
            1: v = {ADIM{1'b1}};
            2: for (int i = 0; i < ADIM / 2; i++) v[i] = 1'b1;
            3: begin
                for (int i = 0; i < r; i++) v[i] = 1'b1;
                s = $urandom_range(1, ADIM - 1);
                v = (v << s) | (v >> (ADIM - s));
            end
            default: for (int w = 0; w < ADIM / 32; w++) v[w*32 +: 32] = $urandom();
        endcase
        return v;
    endfunction

    task automatic drive_all(input int mode);
        for (int r = 0; r < IDIM; r++) iBit[r] = gen(mode, r);
    endtask

    task automatic check_held(input string tag);
        for (int r = 0; r < IDIM; r++) check(tag, 64'(oData[r]), held[r]);
    endtask

    task automatic idle(input int n);
        iStart = 1'b0;
        for (int i = 0; i < n; i++) begin
            drive_all(4);
            tick();
        end
        check("idle_valid", 64'(oValid), 64'(exp_valid));
        check("idle_busy", 64'(oBusy), 64'd0);
        check_held("idle_hold");
    endtask

    // One window: start edge, N sampled cycles, then wait (bounded) for oValid.
    task automatic run_window(input int mode, input int mid_start, input bit hold, input int abort_at);
        int lat;
        int busy_cnt;
        bit got;
        iStart = 1'b1;
        drive_all(4);
        tick();
        check("start_valid_low", 64'(oValid), 64'd0);
        check_held("start_data_held");
        busy_cnt = oBusy ? 1 : 0;
        for (int r = 0; r < IDIM; r++) exp_sum[r] = 0;
        lat = 0;
        got = 1'b0;
        for (int k = 0; k < N + 8; k++) begin
            if (k == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("abort_valid", 64'(oValid), 64'd0);
                check("abort_busy", 64'(oBusy), 64'd0);
                for (int r = 0; r < IDIM; r++) held[r] = 64'd0;
                exp_valid = 1'b0;
                check_held("abort_data");
                iStart = 1'b0;
                #2 rst_n = 1'b1;
                return;
            end
            iStart = hold ? 1'b1 : (k == mid_start);
            if (k < N) begin
                drive_all(mode);
                for (int r = 0; r < IDIM; r++) exp_sum[r] += $countones(iBit[r]);
            end else begin
                drive_all(4);
            end
            tick();
            lat++;
            if (oBusy) busy_cnt++;
            if (oValid) begin
                got = 1'b1;
                break;
            end
        end
        if (!hold) iStart = 1'b0;
        check("valid_seen", 64'(got), 64'd1);
        check("latency", 64'(lat), 64'(N + 1));
        check("busy_cycles", 64'(busy_cnt), 64'(N + 1));
        check("busy_end", 64'(oBusy), 64'd0);
        for (int r = 0; r < IDIM; r++) held[r] = 64'(exp_sum[r]);
        exp_valid = 1'b1;
        check_held("window_total");
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        exp_valid = 1'b0;
        for (int r = 0; r < IDIM; r++) held[r] = 64'd0;
        iStart = 1'b0;
        drive_all(0);
        rst_n = 1'b0;
        #12;
        check("reset_valid", 64'(oValid), 64'd0);
        check("reset_busy", 64'(oBusy), 64'd0);
        check_held("reset_data");
        rst_n = 1'b1;
        idle(3);

        run_window(0, -1, 1'b0, -1);
        check("zero_total_r0", 64'(oData[0]), 64'd0);
        idle(2);
        run_window(1, -1, 1'b0, -1);
        check("full_scale_r5", 64'(oData[5]), 64'(ADIM * N));
        idle(4);
        run_window(2, -1, 1'b0, -1);
        check("bipolar_zero_r9", 64'(oData[9]), 64'(ADIM * N / 2));
        idle(1);
        run_window(3, -1, 1'b0, -1);
        check("row_ramp_r15", 64'(oData[15]), 64'(N * 15));
        idle(2);
        run_window(4, 100, 1'b0, -1);
        idle(3);

        run_window(4, -1, 1'b1, -1);
        run_window(3, -1, 1'b1, -1);
        run_window(4, -1, 1'b0, -1);
        idle(5);

        run_window(4, -1, 1'b0, 50);
        idle(2);
        run_window(1, -1, 1'b0, -1);
        idle(2);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
